instr_encoder: RTL

- Builds 32-bit RV32I instruction words from a format tag, register fields and a full 32-bit signed immediate.
- Scatters the immediate bits into the format-specific fields, checks that the immediate is in range, and attaches a word address from an internal counter.
- Sits between the test/boot-program source and the instruction-memory write port.
- Uses valid/ready handshakes on both sides, with one output register stage.

---
 rtl/instr_encoder_pkg.sv | 37 +++
 rtl/instr_enc_pack.sv | 53 +++++
 rtl/instr_encoder.sv | 110 +++++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared constants for the RV32I instruction encoder: format tags, opcodes,
// immediate range limits and a signed range helper.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam int IS_MIN = -2048;
  localparam int IS_MAX = 2047;
  localparam int B_MIN  = -4096;
  localparam int B_MAX  = 4094;
  localparam int J_MIN  = -1048576;
  localparam int J_MAX  = 1048574;

  function automatic logic in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/instr_enc_pack.sv
// Combinational RV32I field packer: scatters the immediate into the
// format-specific bit positions and flags out-of-range immediates.
module instr_enc_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  always_comb begin
    instr = NOP_WORD;
    err   = 1'b1;
    case (fmt)
      FMT_R: begin
        instr = {funct7, rs2, rs1, funct3, rd, opcode};
        err   = 1'b0;
      end
      FMT_I: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = !in_range(imm, IS_MIN, IS_MAX);
      end
      FMT_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = !in_range(imm, IS_MIN, IS_MAX);
      end
      FMT_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err   = !in_range(imm, B_MIN, B_MAX) || imm[0];
      end
      FMT_U: begin
        instr = {imm[31:12], rd, opcode};
        err   = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = !in_range(imm, J_MIN, J_MAX) || imm[0];
      end
      default: begin
        instr = NOP_WORD;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with one output register stage and word-address
// counter. Optional error counter enabled by macro INSTR_ENC_ERR_CNT_EN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned      AW        = 32,
  parameter logic [AW-1:0]    BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_fmt,
  input  logic [6:0]    in_opcode,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [2:0]    in_funct3,
  input  logic [6:0]    in_funct7,
  input  logic [31:0]   in_imm,
  input  logic          addr_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [AW-1:0] out_addr,
  output logic          out_err
`ifdef INSTR_ENC_ERR_CNT_EN
  ,
  output logic [7:0]    err_cnt
`endif
);

  typedef enum logic {EMPTY, FULL} state_e;

  localparam logic [AW-1:0] ADDR_STEP = AW'(4);

  state_e        state, state_nxt;
  logic          capture;
  logic [AW-1:0] cnt;
  logic [31:0]   pack_instr;
  logic          pack_err;

  instr_enc_pack u_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .instr  (pack_instr),
    .err    (pack_err)
  );

  assign capture = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (capture) state_nxt = FULL;
      FULL:    if (!capture && out_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == FULL);
    in_ready  = (state == EMPTY) | out_ready;
  end

  // Clear takes priority over the running count, even on a capture edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_instr <= '0;
      out_err   <= 1'b0;
      out_addr  <= BASE_ADDR;
      cnt       <= BASE_ADDR;
    end else if (capture) begin
      out_instr <= pack_instr;
      out_err   <= pack_err;
      if (addr_clr) begin
        out_addr <= BASE_ADDR;
        cnt      <= BASE_ADDR + ADDR_STEP;
      end else begin
        out_addr <= cnt;
        cnt      <= cnt + ADDR_STEP;
      end
    end else if (addr_clr) begin
      cnt <= BASE_ADDR;
    end
  end

`ifdef INSTR_ENC_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt <= '0;
    else if (addr_clr)
      err_cnt <= '0;
    else if (out_valid && out_ready && out_err && (err_cnt != '1))
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule
